// File: rtl/sr_fifo_pkg.sv
// sr_fifo_pkg: shared sizing constants and the per-cycle request decode type for the stack-side FIFO.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FIFO_WIDTH/FIFO_DEPTH defaults used by the core-level instance, fifo_req_t decode bundle.
package sr_fifo_pkg;

    // Default geometry used by the core when it instantiates the buffer.
    localparam int FIFO_WIDTH = 16;
    localparam int FIFO_DEPTH = 8;

    // Per-cycle outcome of the push/pop requests after checking the FIFO state.
    typedef struct packed {
        logic push_acc;   // din is written to the tail and wp advances
        logic pop_acc;    // head is consumed and rp advances
        logic ovf_set;    // push dropped because the buffer is full and nothing pops
        logic unf_set;    // pop issued while the buffer is empty
    } fifo_req_t;

endpackage

// File: rtl/sr_fifo_ram.sv
// sr_fifo_ram: DEPTH x WIDTH storage array for sr_fifo, one write port and one read port.
// Latency: write lands on the rising edge; read is combinational (0 cycles).
// Backpressure: none; the owner decides when to write.
// Ports: clk, i_we/i_waddr/i_wdata (sync write), i_raddr -> o_rdata (async read). No reset on the array.
module sr_fifo_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Contents are deliberately not reset; the pointer logic decides what is valid.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sr_fifo.sv
// sr_fifo: first-word-fall-through data buffer between the core's PUSH and POP instructions.
// Latency: dout is combinational from the head (0 cycles); a pushed word is visible after its edge.
// Backpressure: none; pushes when full are dropped (overflow), pops when empty return 0 (underflow).
// Ports: clk, rst_n (async, active-low), din/push, pop -> dout, status empty/full/count/almostFull,
//        sticky overflow/underflow with synchronous errClr.
module sr_fifo
    import sr_fifo_pkg::*;
#(
    parameter int WIDTH       = FIFO_WIDTH,
    parameter int DEPTH       = FIFO_DEPTH,
    parameter int AFULL_LEVEL = DEPTH - 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       din,
    input  logic                   push,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   almostFull,
    output logic                   overflow,
    output logic                   underflow,
    input  logic                   errClr
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [AW:0] AFULL_L = (AW + 1)'(AFULL_LEVEL);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      r_wp;
    logic [AW:0]      r_rp;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_empty;
    logic             w_full;
    logic [AW:0]      w_count;
    logic [WIDTH-1:0] w_rdata;
    fifo_req_t        w_req;

    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[AW-1:0] == r_rp[AW-1:0]) && (r_wp[AW] != r_rp[AW]);
    assign w_count = r_wp - r_rp;

    // Full implies non-empty, so a simultaneous pop always frees the slot the push needs.
    always_comb begin
        w_req          = '0;
        w_req.pop_acc  = pop && !w_empty;
        w_req.push_acc = push && (!w_full || pop);
        w_req.ovf_set  = push && w_full && !pop;
        w_req.unf_set  = pop && w_empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_req.push_acc) begin
                r_wp <= r_wp + PTR_ONE;
            end
            if (w_req.pop_acc) begin
                r_rp <= r_rp + PTR_ONE;
            end
            // A fresh error in the clear cycle wins, so the flag is never lost.
            if (w_req.ovf_set) begin
                r_overflow <= 1'b1;
            end else if (errClr) begin
                r_overflow <= 1'b0;
            end
            if (w_req.unf_set) begin
                r_underflow <= 1'b1;
            end else if (errClr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    sr_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_req.push_acc),
        .i_waddr (r_wp[AW-1:0]),
        .i_wdata (din),
        .i_raddr (r_rp[AW-1:0]),
        .o_rdata (w_rdata)
    );

    // The array is not reset, so mask the stale head while nothing is stored.
    assign dout       = w_empty ? '0 : w_rdata;
    assign empty      = w_empty;
    assign full       = w_full;
    assign count      = w_count;
    assign almostFull = (w_count >= AFULL_L);
    assign overflow   = r_overflow;
    assign underflow  = r_underflow;

endmodule

// File: tb/tb_sr_fifo.sv
module tb_sr_fifo;

    logic        clk;
    logic        rst_n;
    logic [15:0] din;
    logic        push;
    logic        pop;
    logic [15:0] dout;
    logic        empty;
    logic        full;
    logic [3:0]  count;
    logic        almostFull;
    logic        overflow;
    logic        underflow;
    logic        errClr;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] q[$];

    sr_fifo #(
        .WIDTH       (16),
        .DEPTH       (8),
        .AFULL_LEVEL (6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .push       (push),
        .pop        (pop),
        .dout       (dout),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .almostFull (almostFull),
        .overflow   (overflow),
        .underflow  (underflow),
        .errClr     (errClr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs are applied 1 time unit after a rising edge and held until the next one.
    task automatic drive(input logic ps, input logic pp, input logic [15:0] d, input logic ec);
        push   = ps;
        pop    = pp;
        din    = d;
        errClr = ec;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        push   = 1'b0;
        pop    = 1'b0;
        din    = 16'h0;
        errClr = 1'b0;
    endtask

    task automatic do_push(input logic [15:0] d);
        drive(1'b1, 1'b0, d, 1'b0);
        tick();
    endtask

    // Pop once and check the head shown during the popping cycle.
    task automatic do_pop(input string tag, input logic [15:0] exp);
        drive(1'b0, 1'b1, 16'h0, 1'b0);
        #1;
        chk(tag, {16'h0, dout}, {16'h0, exp});
        tick();
    endtask

    initial begin
        rst_n  = 1'b0;
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        #12;
        rst_n = 1'b1;

        // Reset state
        chk("rst_dout",  {16'h0, dout}, 32'h0);
        chk("rst_empty", {31'h0, empty}, 32'h1);
        chk("rst_full",  {31'h0, full}, 32'h0);
        chk("rst_count", {28'h0, count}, 32'h0);
        chk("rst_afull", {31'h0, almostFull}, 32'h0);
        chk("rst_ovf",   {31'h0, overflow}, 32'h0);
        chk("rst_unf",   {31'h0, underflow}, 32'h0);
        @(posedge clk);
        #1;

        // Three pushes, three pops, FIFO order
        do_push(16'h1111);
        chk("t1_first_visible", {16'h0, dout}, 32'h1111);
        do_push(16'h2222);
        do_push(16'h3333);
        chk("t1_count3", {28'h0, count}, 32'd3);
        chk("t1_not_empty", {31'h0, empty}, 32'h0);
        do_pop("t1_pop0", 16'h1111);
        do_pop("t1_pop1", 16'h2222);
        do_pop("t1_pop2", 16'h3333);
        chk("t1_empty", {31'h0, empty}, 32'h1);
        chk("t1_dout0", {16'h0, dout}, 32'h0);

        // Fill to full, almostFull threshold, overflow on ninth push
        for (int i = 0; i < 8; i++) begin
            do_push(16'(i));
            if (i == 4) chk("t2_afull_at5", {31'h0, almostFull}, 32'h0);
            if (i == 5) chk("t2_afull_at6", {31'h0, almostFull}, 32'h1);
            if (i == 6) chk("t2_full_at7", {31'h0, full}, 32'h0);
        end
        chk("t2_full", {31'h0, full}, 32'h1);
        chk("t2_count8", {28'h0, count}, 32'd8);
        chk("t2_ovf_before", {31'h0, overflow}, 32'h0);
        do_push(16'hFFFF);
        chk("t2_ovf", {31'h0, overflow}, 32'h1);
        chk("t2_count_after_drop", {28'h0, count}, 32'd8);
        for (int i = 0; i < 8; i++) begin
            do_pop($sformatf("t2_pop%0d", i), 16'(i));
        end
        chk("t2_empty", {31'h0, empty}, 32'h1);
        chk("t2_ovf_sticky", {31'h0, overflow}, 32'h1);
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        tick();
        chk("t2_ovf_clr", {31'h0, overflow}, 32'h0);

        // Underflow and errClr priority
        do_pop("t3_pop_empty_dout", 16'h0000);
        chk("t3_unf", {31'h0, underflow}, 32'h1);
        chk("t3_count0", {28'h0, count}, 32'd0);
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        tick();
        chk("t3_unf_clr", {31'h0, underflow}, 32'h0);
        drive(1'b0, 1'b1, 16'h0, 1'b1);
        tick();
        chk("t3_unf_prio", {31'h0, underflow}, 32'h1);
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        tick();
        chk("t3_unf_clr2", {31'h0, underflow}, 32'h0);

        // Full with simultaneous push and pop reuses the freed slot
        for (int i = 0; i < 8; i++) do_push(16'(i));
        drive(1'b1, 1'b1, 16'hABCD, 1'b0);
        #1;
        chk("t4_pp_dout", {16'h0, dout}, 32'h0000);
        tick();
        chk("t4_count8", {28'h0, count}, 32'd8);
        chk("t4_full", {31'h0, full}, 32'h1);
        chk("t4_no_ovf", {31'h0, overflow}, 32'h0);
        for (int i = 1; i < 8; i++) do_pop($sformatf("t4_drain%0d", i), 16'(i));
        do_pop("t4_drain_last", 16'hABCD);
        chk("t4_empty", {31'h0, empty}, 32'h1);

        // Empty with simultaneous push and pop
        drive(1'b1, 1'b1, 16'h5A5A, 1'b0);
        #1;
        chk("t5_pp_dout", {16'h0, dout}, 32'h0);
        tick();
        chk("t5_unf", {31'h0, underflow}, 32'h1);
        chk("t5_count1", {28'h0, count}, 32'd1);
        chk("t5_next_dout", {16'h0, dout}, 32'h5A5A);
        do_pop("t5_pop", 16'h5A5A);
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        tick();

        // Streaming push/pop pairs across pointer wrap, then async reset
        for (int i = 0; i < 3; i++) begin
            q.push_back(16'h0100 + 16'(i));
            do_push(16'h0100 + 16'(i));
        end
        for (int j = 0; j < 20; j++) begin
            drive(1'b1, 1'b1, 16'h0200 + 16'(j), 1'b0);
            #1;
            chk($sformatf("t6_pair%0d", j), {16'h0, dout}, {16'h0, q[0]});
            tick();
            void'(q.pop_front());
            q.push_back(16'h0200 + 16'(j));
            if (j % 5 == 4) chk($sformatf("t6_count%0d", j), {28'h0, count}, 32'd3);
        end
        chk("t6_no_unf", {31'h0, underflow}, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_count", {28'h0, count}, 32'd0);
        chk("t6_rst_empty", {31'h0, empty}, 32'h1);
        chk("t6_rst_dout", {16'h0, dout}, 32'h0);
        #1;
        rst_n = 1'b1;
        tick();
        chk("t6_post_rst_empty", {31'h0, empty}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
